relu_maxpool: RTL
=================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits (signed fixed point).
REQ-002 SHALL have parameter Q, default 12, fractional bits; Q is pass-through only, with no rescaling.
REQ-003 SHALL have parameter M, default 4, input feature-map dimension (convolver n-k+1).
REQ-004 SHALL have parameter P, default 2, pooling window size and stride.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port en, input, 1, global enable; when low, all state freezes.
REQ-008 SHALL have port data_in, input, N, convolver result, raster order.
REQ-009 SHALL have port valid_in, input, 1, data_in qualifier; one element per asserted cycle.
REQ-010 SHALL have port pool_out, output, N, pooled result.
REQ-011 SHALL have port valid_out, output, 1, single-cycle qualifier for pool_out.
REQ-012 SHALL have port done, output, 1, single-cycle pulse after the last output of a frame.

Function
REQ-013 SHALL apply ReLU per sample: a negative signed data_in becomes 0; otherwise the value is unchanged.
REQ-014 SHALL use an FSM with states IDLE, ACCUM and FLUSH: IDLE->ACCUM on the first accepted valid_in; ACCUM->FLUSH when the last sample of the MxM frame is accepted; FLUSH->IDLE after one cycle.
REQ-015 SHALL accept a sample only when en=1, valid_in=1, and state is IDLE or ACCUM.
REQ-016 SHALL ignore valid_in in FLUSH.
REQ-017 SHALL keep col counter 0..M-1 and row counter 0..M-1; col wraps to 0 and row increments on col==M-1; both wrap to 0 at frame end.
REQ-018 SHALL keep a horizontal running max over the P columns of a window; it reloads with the sample at each col%P==0.
REQ-019 SHALL include a row buffer of M/P entries holding the vertical running max per pooled column.
REQ-020 SHALL write the horizontal max directly into the row buffer entry when row%P==0; for other rows it SHALL write the max of the entry and the horizontal max.
REQ-021 SHALL complete a window on a sample with col%P==P-1 and row%P==P-1; on the next cycle pool_out SHALL equal the window max and valid_out=1 (latency 1 cycle).
REQ-022 SHALL produce exactly (M/P)^2 outputs per frame, in raster order of the pooled map.
REQ-023 SHALL assert done for exactly one cycle, in FLUSH, i.e. the cycle after the last valid_out.
REQ-024 SHALL make all max comparisons signed; since post-ReLU values are ≥0, the output is never negative.
REQ-025 SHALL, when en=0, hold counters, buffer and state, drive valid_out=0 and done=0, and hold pool_out.
REQ-026 SHALL hold pool_out between outputs; valid_out SHALL be 0 whenever no window completed on the previous cycle.
REQ-027 SHALL fail elaboration if M%P!=0 or P<1.
REQ-028 SHALL accept gaps in valid_in, with no timeout and counters holding.
REQ-029 SHALL accept back-to-back frames: a sample arriving in the cycle after FLUSH starts a new frame.

Reset
REQ-030 SHALL, with rst high at a clock edge, set state=IDLE, counters=0, row buffer=0, horizontal max=0, pool_out=0, valid_out=0 and done=0.
REQ-031 SHALL let rst override en and valid_in.
REQ-032 SHALL let a mid-frame reset discard the partial frame with no output emitted; the next accepted sample is treated as row 0, col 0.

Structure
REQ-033 SHALL place the FSM state encodings and a ReLU helper function in the shared CNN package, reused by the convolver stage.
REQ-034 SHALL contain a single sub-module, pool_row_buffer: M/P x N registers with one read port and one write port indexed by col/P.
REQ-035 SHALL be directly connectable to the convolver outputs: conv_out->data_in, valid_out->valid_in.

Verification (M=4, P=2, integer values in data_in)
REQ-036 SHALL be tested with a ramp of 1..16 streamed continuously: pool_out sequence 6, 8, 14, 16, each with a 1-cycle valid_out, then done 1 cycle after the 16.
REQ-037 SHALL be tested with all 16 inputs at -5 (0xFFFB): four outputs of 0, then done.
REQ-038 SHALL be tested with a mixed-sign frame, window {-3, 7, 2, -8} in the top-left window with all other samples -1: outputs 7, 0, 0, 0.
REQ-039 SHALL be tested with the ramp, valid_in deasserted every other cycle and en low for 3 cycles mid-frame: same outputs as REQ-036, with no valid_out while en=0.
REQ-040 SHALL be tested with rst asserted after sample 9 followed by a fresh ramp 1..16: exactly four outputs 6, 8, 14, 16, and no output from the aborted frame.
REQ-041 SHALL be tested with two back-to-back frames (ramp, then ramp+100): eight outputs 6, 8, 14, 16, 106, 108, 114, 116, with two done pulses.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// Shared CNN definitions: pooling-stage FSM states and the ReLU helper.
package relu_maxpool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } pool_state_e;

  // A signed sample passes through ReLU unchanged unless its sign bit is set.
  function automatic logic relu_pass(input logic sign_bit);
    return !sign_bit;
  endfunction

endpackage

// File: rtl/relu_maxpool_row_buffer.sv
// Row buffer for max pooling: one entry per pooled column, holding the
// vertical running max. One combinational read port, one write port.
module pool_row_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by PxP / stride-P max pooling over an MxM raster-order frame.
// Handshake: a sample is taken on a clock edge where en && valid_in and the
// FSM is not in FLUSH; valid_out/done are one-cycle pulses, no backpressure.
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 12,
  parameter int M = 4,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic [N-1:0] pool_out,
  output logic         valid_out,
  output logic         done,
  output logic [1:0]   state_dbg
);

  if (P < 1 || (M % ((P < 1) ? 1 : P)) != 0) begin : g_bad_geometry
    $error("relu_maxpool: M must be a multiple of P and P >= 1");
  end
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("relu_maxpool: Q must lie in 0..N-1");
  end

  localparam int D  = (P < 1) ? 1 : M / P;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  pool_state_e   state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [N-1:0]  hmax_q, hmax_d;
  logic [N-1:0]  pool_q, pool_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          accept;
  logic          col_first, col_last_in_win, row_first, row_last_in_win;
  logic          frame_last;
  logic [N-1:0]  relu_val, hmax_new, vmax_new, buf_rd;
  logic [AW-1:0] buf_addr;
  logic          buf_we;

  assign accept          = en && valid_in && (state_q != ST_FLUSH);
  assign col_first       = (int'(col_q) % P) == 0;
  assign col_last_in_win = (int'(col_q) % P) == P - 1;
  assign row_first       = (int'(row_q) % P) == 0;
  assign row_last_in_win = (int'(row_q) % P) == P - 1;
  assign frame_last      = (col_q == CW'(M - 1)) && (row_q == CW'(M - 1));
  assign buf_addr        = AW'(int'(col_q) / P);

  assign relu_val = relu_pass(data_in[N-1]) ? data_in : '0;
  assign hmax_new = col_first ? relu_val : smax(hmax_q, relu_val);
  // First row of a window band overwrites stale data from the previous band.
  assign vmax_new = row_first ? hmax_new : smax(buf_rd, hmax_new);
  assign buf_we   = accept && col_last_in_win;

  pool_row_buffer #(
    .N     (N),
    .DEPTH (D),
    .AW    (AW)
  ) u_row_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_we),
    .wr_addr (buf_addr),
    .wr_data (vmax_new),
    .rd_addr (buf_addr),
    .rd_data (buf_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hmax_d  = hmax_q;
    pool_d  = pool_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          hmax_d = hmax_new;
          if (col_last_in_win && row_last_in_win) begin
            pool_d  = vmax_new;
            valid_d = 1'b1;
          end
          if (col_q == CW'(M - 1)) begin
            col_d = '0;
            row_d = (row_q == CW'(M - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          state_d = frame_last ? ST_FLUSH : ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        if (en) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      hmax_q  <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hmax_q  <= hmax_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign pool_out  = pool_q;
  assign valid_out = valid_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
